// File: rtl/operand_capture_if.sv
// Operand pair bus between the capture block and the downstream stage.
// master drives a/b/out_valid; slave returns out_ready.
interface operand_capture_if #(
  parameter int M = 4
);
  logic [M-1:0] a;
  logic [M-1:0] b;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output a,
    output b,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  a,
    input  b,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/operand_capture.sv
// Captures two operands from switches on debounced load presses.
// Ports: clk, rst_n, sw, btn_load, btn_clear, op (a/b/valid/ready), state_dbg.
module operand_capture #(
  parameter int M   = 4,
  parameter int DEB = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [M-1:0] sw,
  input  logic         btn_load,
  input  logic         btn_clear,
  operand_capture_if.master op,
  output logic [1:0]   state_dbg
);

  localparam int CW = $clog2(DEB + 1);

  typedef enum logic [1:0] {
    LOAD_A = 2'b00,
    LOAD_B = 2'b01,
    VALID  = 2'b10
  } state_t;

  logic [1:0]    rsync;
  logic          rst_i;
  logic [1:0]    ld_s;
  logic [1:0]    cl_s;
  logic          deb;
  logic          deb_q;
  logic [CW-1:0] cnt;
  logic          pulse;
  logic          clr;
  state_t        state;
  state_t        state_n;
  logic [M-1:0]  a_q;
  logic [M-1:0]  a_n;
  logic [M-1:0]  b_q;
  logic [M-1:0]  b_n;
  logic          vld_q;

  // assert immediately, release on a clock edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rsync <= 2'b00;
    else        rsync <= {rsync[0], 1'b1};
  end

  assign rst_i = rsync[1];

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      ld_s <= 2'b00;
      cl_s <= 2'b00;
    end else begin
      ld_s <= {ld_s[0], btn_load};
      cl_s <= {cl_s[0], btn_clear};
    end
  end

  // level flips after DEB consecutive differing samples
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      deb   <= 1'b0;
      deb_q <= 1'b0;
      cnt   <= '0;
    end else begin
      deb_q <= deb;
      if (ld_s[1] != deb) begin
        if (cnt == CW'(DEB - 1)) begin
          deb <= ld_s[1];
          cnt <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign pulse = deb & ~deb_q;
  assign clr   = cl_s[1];

  always_comb begin
    state_n = state;
    a_n     = a_q;
    b_n     = b_q;
    if (clr) begin
      state_n = LOAD_A;
      a_n     = '0;
      b_n     = '0;
    end else begin
      case (state)
        LOAD_A: begin
          if (pulse) begin
            a_n     = sw;
            state_n = LOAD_B;
          end
        end
        LOAD_B: begin
          if (pulse) begin
            b_n     = sw;
            state_n = VALID;
          end
        end
        VALID: begin
          if (op.out_ready) state_n = LOAD_A;
        end
        default: state_n = LOAD_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      state <= LOAD_A;
      a_q   <= '0;
      b_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      state <= state_n;
      a_q   <= a_n;
      b_q   <= b_n;
      vld_q <= (state_n == VALID);
    end
  end

  assign op.a         = a_q;
  assign op.b         = b_q;
  assign op.out_valid = vld_q;
  assign state_dbg    = state;

endmodule

// File: tb/tb_operand_capture.sv
// Bench for operand_capture: directed scenarios plus random
// presses checked against a press-level reference model.
module tb_operand_capture;

  localparam int M   = 4;
  localparam int DEB = 4;
  localparam int NC  = 600;

  logic         clk;
  logic         rst_n;
  logic [M-1:0] sw;
  logic         btn_load;
  logic         btn_clear;
  logic [1:0]   state_dbg;

  operand_capture_if #(.M(M)) bus ();

  operand_capture #(.M(M), .DEB(DEB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw        (sw),
    .btn_load  (btn_load),
    .btn_clear (btn_clear),
    .op        (bus.master),
    .state_dbg (state_dbg)
  );

  int n_chk;
  int n_fail;

  bit           ld  [NC];
  bit           cl  [NC];
  bit           rd  [NC];
  bit           cap [NC];
  logic [M-1:0] swv [NC];

  int           m_st;
  logic [M-1:0] m_a;
  logic [M-1:0] m_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [M-1:0] v);
    sw       = v;
    btn_load = 1'b1;
    repeat (10) tick();
    btn_load = 1'b0;
    repeat (12) tick();
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    sw        = '0;
    btn_load  = 1'b0;
    btn_clear = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    check("rst_a", bus.a, 0);
    check("rst_b", bus.b, 0);
    check("rst_vld", bus.out_valid, 0);
    check("rst_st", state_dbg, 0);
    #2 rst_n = 1'b1;
    repeat (5) tick();

    // glitch shorter than DEB
    sw       = 4'h9;
    btn_load = 1'b1;
    repeat (3) tick();
    btn_load = 1'b0;
    repeat (15) tick();
    check("glitch_st", state_dbg, 0);
    check("glitch_a", bus.a, 0);
    check("glitch_b", bus.b, 0);

    // capture a on edge DEB+3
    sw       = 4'h3;
    btn_load = 1'b1;
    repeat (6) tick();
    check("a_pre", bus.a, 0);
    check("st_pre", state_dbg, 0);
    tick();
    check("a_cap", bus.a, 3);
    check("st_a", state_dbg, 1);
    sw = 4'hF;
    repeat (3) tick();
    btn_load = 1'b0;
    repeat (12) tick();
    check("a_hold", bus.a, 3);
    check("st_b_wait", state_dbg, 1);

    sw       = 4'h5;
    btn_load = 1'b1;
    repeat (6) tick();
    check("vld_pre", bus.out_valid, 0);
    check("b_pre", bus.b, 0);
    tick();
    check("b_cap", bus.b, 5);
    check("st_v", state_dbg, 2);
    check("vld_up", bus.out_valid, 1);
    sw = 4'h0;
    repeat (3) tick();
    btn_load = 1'b0;
    repeat (12) tick();

    // load ignored in VALID
    press(4'hC);
    check("v_ign_a", bus.a, 3);
    check("v_ign_b", bus.b, 5);

    // handshake wait then accept
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hs_wait_v", bus.out_valid, 1);
      check("hs_wait_a", bus.a, 3);
      check("hs_wait_b", bus.b, 5);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("hs_vld", bus.out_valid, 0);
    check("hs_st", state_dbg, 0);
    check("hs_a", bus.a, 3);
    check("hs_b", bus.b, 5);

    // clear vs load pulse in LOAD_B
    press(4'h7);
    check("cl_prep", state_dbg, 1);
    sw       = 4'h9;
    btn_load = 1'b1;
    repeat (4) tick();
    btn_clear = 1'b1;
    tick();
    btn_clear = 1'b0;
    repeat (2) tick();
    check("clr_st", state_dbg, 0);
    check("clr_a", bus.a, 0);
    check("clr_b", bus.b, 0);
    repeat (3) tick();
    btn_load = 1'b0;
    repeat (12) tick();
    check("clr_st2", state_dbg, 0);

    // async reset in VALID
    press(4'hA);
    press(4'hB);
    check("ar_prep", bus.out_valid, 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("ar_vld", bus.out_valid, 0);
    check("ar_a", bus.a, 0);
    check("ar_b", bus.b, 0);
    check("ar_st", state_dbg, 0);
    repeat (2) tick();
    #2 rst_n = 1'b1;
    repeat (4) tick();
    btn_load = 1'b1;
    repeat (3) tick();
    btn_load = 1'b0;
    repeat (15) tick();
    check("ar_nocap_st", state_dbg, 0);
    check("ar_nocap_a", bus.a, 0);

    // random phase: press-level model
    for (int i = 0; i < NC; i++) begin
      ld[i]  = 1'b0;
      cap[i] = 1'b0;
      cl[i]  = ($urandom_range(0, 39) == 0);
      rd[i]  = $urandom_range(0, 1);
      swv[i] = M'($urandom);
    end
    begin
      int n;
      n = 5;
      while (n < NC - 40) begin
        int len;
        len = $urandom_range(1, 2 * DEB + 4);
        for (int k = 0; k < len; k++) ld[n + k] = 1'b1;
        if (len >= DEB) cap[n + DEB + 2] = 1'b1;
        n = n + len + DEB + 4 + $urandom_range(0, 6);
      end
    end
    m_st = 0;
    m_a  = '0;
    m_b  = '0;
    for (int n = 0; n < NC; n++) begin
      sw            = swv[n];
      btn_load      = ld[n];
      btn_clear     = cl[n];
      bus.out_ready = rd[n];
      @(posedge clk);
      if (n >= 2 && cl[n - 2]) begin
        m_st = 0;
        m_a  = '0;
        m_b  = '0;
      end else if (m_st == 0) begin
        if (cap[n]) begin
          m_a  = swv[n];
          m_st = 1;
        end
      end else if (m_st == 1) begin
        if (cap[n]) begin
          m_b  = swv[n];
          m_st = 2;
        end
      end else begin
        if (rd[n]) m_st = 0;
      end
      #1;
      check("rnd_a", bus.a, m_a);
      check("rnd_b", bus.b, m_b);
      check("rnd_st", state_dbg, m_st);
      check("rnd_vld", bus.out_valid, (m_st == 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
